// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: NOP encoding, register-field slices, fetch FSM states.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam int REG_W   = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [REG_W-1:0] get_rd(input logic [31:0] instr);
    return instr[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_rs1(input logic [31:0] instr);
    return instr[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_rs2(input logic [31:0] instr);
    return instr[RS2_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush/hold/load and registered rd/rs1/rs2 decode.
// Latency: 1 cycle from load inputs to outputs.
// Backpressure: hold freezes every field; flush overrides hold and loads a bubble.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             load,
  input  logic [31:0]      load_pc,
  input  logic [31:0]      load_instr,
  output logic             valid,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2
);

  // Flush beats hold beats load; otherwise a bubble with the PC left as is.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      rd    <= '0;
      rs1   <= '0;
      rs2   <= '0;
    end else if (flush || (!hold && !load)) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      rd    <= '0;
      rs1   <= '0;
      rs2   <= '0;
    end else if (!hold) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
      rd    <= get_rd(load_instr);
      rs1   <= get_rs1(load_instr);
      rs2   <= get_rs2(load_instr);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, one outstanding imem request, loads IF/ID (IF_PERF_CNT_EN adds perf counters).
// Latency: imem response in cycle N appears in IF/ID at N+1; 2 cycles/instr with 0-wait memory.
// Backpressure: stall holds IF/ID and parks a returning word in a 1-entry buffer; redirect flushes.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic [REG_W-1:0] if_id_rd,
  output logic [REG_W-1:0] if_id_rs1,
  output logic [REG_W-1:0] if_id_rs2
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_bubble_cnt
`endif
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;
  logic         kill;
  logic         pend_valid;
  logic [31:0]  pend_pc;
  logic [31:0]  pend_instr;

  logic [31:0]  redirect_target;
  logic         deliver;
  logic [31:0]  deliver_pc;
  logic [31:0]  deliver_instr;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_target = redirect_pc & ~32'h3;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = fetch_pc;

  // An instruction reaches IF/ID either straight from memory or from the pending buffer.
  always_comb begin
    deliver       = 1'b0;
    deliver_pc    = req_pc;
    deliver_instr = imem_rdata;
    if (!redirect_valid && !stall) begin
      if (state == ST_WAIT && imem_rvalid && !kill) begin
        deliver = 1'b1;
      end else if (state == ST_HOLD) begin
        deliver       = 1'b1;
        deliver_pc    = pend_pc;
        deliver_instr = pend_instr;
      end
    end
  end

  // Fetch FSM; redirect is evaluated first and wins in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FETCH;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc    <= RESET_PC;
      pend_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_target;
      pend_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          // A request granted this cycle belongs to the old path.
          if (imem_gnt) begin
            state <= ST_WAIT;
            kill  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_FETCH;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_gnt) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= ST_FETCH;
            end else if (!stall) begin
              state <= ST_FETCH;
            end else begin
              pend_valid <= 1'b1;
              pend_pc    <= req_pc;
              pend_instr <= imem_rdata;
              state      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            pend_valid <= 1'b0;
            state      <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .hold       (stall),
    .load       (deliver),
    .load_pc    (deliver_pc),
    .load_instr (deliver_instr),
    .valid      (if_id_valid),
    .pc         (if_id_pc),
    .instr      (if_id_instr),
    .rd         (if_id_rd),
    .rs1        (if_id_rs1),
    .rs2        (if_id_rs2)
  );

`ifdef IF_PERF_CNT_EN
  // Every non-reset cycle either loads a real instruction or counts as a bubble/hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (deliver) begin
      perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
    end else begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with RESET_PC = 0x100.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Perf counters are only checked when IF_PERF_CNT_EN is defined.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [4:0]  if_id_rd;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int run_cycles = 0;

  localparam logic [31:0] I_ADD  = 32'h00A2_8533;  // add x10, x5, x10
  localparam logic [31:0] I_ADDI = 32'h0031_0093;  // addi x1, x2, 3
  localparam logic [31:0] I_C    = 32'h0074_01B3;  // add x3, x8, x7
  localparam logic [31:0] I_D    = 32'h01F0_0F93;  // addi x31, x0, 31

  if_fetch_stage #(
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_rd       (if_id_rd),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    if (!reset) run_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd_dat,
                       input logic st, input logic rdv, input logic [31:0] rpc);
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = rd_dat;
    stall          = st;
    redirect_valid = rdv;
    redirect_pc    = rpc;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
    check({tag, "_pc"}, if_id_pc, pc);
    check({tag, "_instr"}, if_id_instr, instr);
    check({tag, "_fields"}, {17'd0, if_id_rd, if_id_rs1, if_id_rs2}, {17'd0, rd, rs1, rs2});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    step();
    step();
    check_ifid("reset", 0, 32'h100, 32'h13, 0, 0, 0);
    check_req("reset", 1, 32'h100);

    // Sequential fetch: grant same cycle, response next cycle.
    reset = 1'b0;
    check_req("first", 1, 32'h100);
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    check_req("wait0", 0, 32'h0);
    drive(0, 1, I_ADD, 0, 0, 32'h0); step();
    check_ifid("ld100", 1, 32'h100, I_ADD, 5'd10, 5'd5, 5'd10);
    check_req("req104", 1, 32'h104);
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    check_ifid("bub1", 0, 32'h100, 32'h13, 0, 0, 0);
    drive(0, 1, I_ADDI, 0, 0, 32'h0); step();
    check_ifid("ld104", 1, 32'h104, I_ADDI, 5'd1, 5'd2, 5'd3);
    check_req("req108", 1, 32'h108);

    // Response arrives under stall: buffered, held 3 cycles, released when stall drops.
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 1, I_C, 1, 0, 32'h0); step();
    check_ifid("hold1", 0, 32'h104, 32'h13, 0, 0, 0);
    check_req("hold1", 0, 32'h0);
    drive(0, 0, 32'h0, 1, 0, 32'h0); step();
    check_req("hold2", 0, 32'h0);
    step();
    check_ifid("hold3", 0, 32'h104, 32'h13, 0, 0, 0);
    check_req("hold3", 0, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 32'h0); step();
    check_ifid("ld108", 1, 32'h108, I_C, 5'd3, 5'd8, 5'd7);
    check_req("req10c", 1, 32'h10C);

    // Redirect during WAIT without response: old response must be dropped.
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 0, 32'h0, 0, 1, 32'h203); step();
    check_ifid("rdw", 0, 32'h108, 32'h13, 0, 0, 0);
    check_req("rdw", 0, 32'h0);
    drive(0, 1, I_D, 0, 0, 32'h0); step();
    check_ifid("rdw_drop", 0, 32'h108, 32'h13, 0, 0, 0);
    check_req("req200", 1, 32'h200);

    // Redirect together with rvalid: data dropped, new target fetched next cycle.
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 1, I_D, 0, 1, 32'h300); step();
    check_ifid("rdrv", 0, 32'h108, 32'h13, 0, 0, 0);
    check_req("req300", 1, 32'h300);

    // Redirect together with grant: granted request killed; then wrap at top of memory.
    drive(1, 0, 32'h0, 0, 1, 32'hFFFF_FFFE); step();
    check_req("rdg_wait", 0, 32'h0);
    drive(0, 1, I_D, 0, 0, 32'h0); step();
    check_ifid("rdg_drop", 0, 32'h108, 32'h13, 0, 0, 0);
    check_req("reqtop", 1, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 1, I_D, 0, 0, 32'h0); step();
    check_ifid("ldtop", 1, 32'hFFFF_FFFC, I_D, 5'd31, 5'd0, 5'd31);
    check_req("wrap0", 1, 32'h0);

`ifdef IF_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd4);
    check("perf_bubble", perf_bubble_cnt, run_cycles - 4);
`endif

    // Reset while a response is parked in HOLD.
    drive(1, 0, 32'h0, 0, 0, 32'h0); step();
    drive(0, 1, I_ADD, 1, 0, 32'h0); step();
    check_req("pre_rst_hold", 0, 32'h0);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    reset = 1'b1; step();
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    check_ifid("rst_hold", 0, 32'h100, 32'h13, 0, 0, 0);
    check_req("rst_hold", 1, 32'h100);
    reset = 1'b0; step();
    check_ifid("after_rst", 0, 32'h100, 32'h13, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
